// File: rtl/muldiv_seq_ex_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ex_pkg
// Shared EX-stage definitions used by the multi-cycle multiply/divide
// sequencer and by the EX-level ALU mux:
//   - ALU operation codes for the shared 2-bit add/sub/or/and ALU
//   - multiply/divide opcode encoding
//   - sequencer state encoding
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package muldiv_seq_ex_pkg;

  // Shared ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  // Multiply/divide opcode; bit 1 separates the divide family from multiply
  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_ex.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ex
// Multi-cycle unsigned multiply/divide sequencer for the EX stage. Drives the
// shared ALU once per cycle for XLEN steps: shift-add for MUL/MULHU, restoring
// division for DIVU/REMU. Holds the pipeline with stall_req while running and
// presents the result with a one-cycle done pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   operation request, sampled only in IDLE
//   flush      in   abort current operation
//   op         in   00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1, rs2   in   multiplicand/dividend, multiplier/divisor
//   alu_out    in   shared ALU result (single-cycle combinational path)
//   alu_op_a   out  ALU operand A
//   alu_op_b   out  ALU operand B
//   alu_signal out  ALU op select (only add/sub issued)
//   busy       out  state is not IDLE
//   stall_req  out  pipeline hold
//   done       out  one-cycle result-valid pulse
//   result     out  registered result
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module muldiv_seq_ex
  import muldiv_seq_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] alu_op_a,
  output logic [XLEN-1:0] alu_op_b,
  output logic [1:0]      alu_signal,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  md_state_e        state, state_n;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt;

  // Working registers shared by both algorithms:
  //   acc   : hi  (multiply) / rem  (divide)
  //   shreg : lo  (multiply) / quo  (divide)
  //   oper  : mcand (multiply) / dvsr (divide)
  logic [XLEN-1:0] acc, shreg, oper;
  logic [XLEN-1:0] acc_n, shreg_n;

  // Previous result, restored if an operation is flushed while in DONE
  logic [XLEN-1:0] result_prev;
  logic [XLEN-1:0] res_n;

  logic            is_mul;
  logic            carry;
  logic            m_bit;
  logic            ge;
  logic [XLEN-1:0] sh;

  assign is_mul = (op_q == MD_MUL) || (op_q == MD_MULHU);

  // ---------------------------------------------------------------------------
  // FSM next-state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_n   = state;
    busy      = (state != ST_IDLE);
    stall_req = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_req = start && !flush;
        if (start && !flush) state_n = ST_RUN;
      end
      ST_RUN: begin
        stall_req = 1'b1;
        if (flush)                 state_n = ST_IDLE;
        else if (cnt == LAST_CNT)  state_n = ST_DONE;
      end
      ST_DONE: begin
        // A flush in DONE kills the operation, so the pulse is suppressed
        done    = !flush;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step datapath: ALU operands and next working-register values
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_op_a   = '0;
    alu_op_b   = '0;
    alu_signal = ALU_ADD;
    acc_n      = acc;
    shreg_n    = shreg;
    carry      = 1'b0;
    // Remainder shifted left by one with the next dividend bit: 33-bit value
    // split into its low word and the bit that falls off the top.
    sh         = {acc[XLEN-2:0], shreg[XLEN-1]};
    m_bit      = acc[XLEN-1];
    ge         = 1'b0;
    if (state == ST_RUN) begin
      if (is_mul) begin
        alu_op_a   = acc;
        alu_op_b   = shreg[0] ? oper : '0;
        alu_signal = ALU_ADD;
        // Unsigned overflow of hi + addend shows up as a wrapped sum
        carry      = (alu_out < acc);
        acc_n      = {carry, alu_out[XLEN-1:1]};
        shreg_n    = {alu_out[0], shreg[XLEN-1:1]};
      end else begin
        alu_op_a   = sh;
        alu_op_b   = oper;
        alu_signal = ALU_SUB;
        // With the top bit set the shifted remainder exceeds any divisor, and
        // the ALU's wrapped difference is still the correct low word.
        ge         = m_bit || (sh >= oper);
        acc_n      = ge ? alu_out : sh;
        shreg_n    = {shreg[XLEN-2:0], ge};
      end
    end
  end

  // Result selected from the values produced by the final step
  always_comb begin
    case (op_q)
      MD_MUL:   res_n = shreg_n;
      MD_MULHU: res_n = acc_n;
      MD_DIVU:  res_n = shreg_n;
      MD_REMU:  res_n = acc_n;
      default:  res_n = shreg_n;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= MD_MUL;
      cnt         <= '0;
      acc         <= '0;
      shreg       <= '0;
      oper        <= '0;
      result      <= '0;
      result_prev <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op_q  <= md_op_e'(op);
            cnt   <= '0;
            acc   <= '0;
            // Multiply: lo = multiplier, mcand = multiplicand.
            // Divide:   quo = dividend,  dvsr  = divisor.
            shreg <= op[1] ? rs1 : rs2;
            oper  <= op[1] ? rs2 : rs1;
          end
        end
        ST_RUN: begin
          if (!flush) begin
            acc   <= acc_n;
            shreg <= shreg_n;
            cnt   <= cnt + CNT_W'(1);
            // Result is written on the last step edge so it is valid during
            // DONE, when the EX/MEM register is allowed to capture it.
            if (cnt == LAST_CNT) begin
              result_prev <= result;
              result      <= res_n;
            end
          end
        end
        ST_DONE: begin
          if (flush) result <= result_prev;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ex.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq_ex
// Self-checking bench for muldiv_seq_ex. A cycle-level model built on plain
// arithmetic (64-bit product, / and %) tracks the expected busy/stall/done/
// result behaviour; a negedge compare process checks the DUT every cycle, and
// directed operations check hand-computed results and the 33-cycle latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_muldiv_seq_ex;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            flush;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1, rs2;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] alu_op_a, alu_op_b;
  logic [1:0]      alu_signal;
  logic            busy, stall_req, done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_seq_ex #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flush      (flush),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .alu_out    (alu_out),
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_signal (alu_signal),
    .busy       (busy),
    .stall_req  (stall_req),
    .done       (done),
    .result     (result)
  );

  // Stand-in for the shared EX ALU
  always_comb begin
    case (alu_signal)
      2'b00:   alu_out = alu_op_a + alu_op_b;
      2'b01:   alu_out = alu_op_a - alu_op_b;
      2'b10:   alu_out = alu_op_a | alu_op_b;
      default: alu_out = alu_op_a & alu_op_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an operation
  function automatic logic [31:0] ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Model: phase 0 idle, 1..32 running steps, 33 result-valid cycle
  // ---------------------------------------------------------------------------
  int          phase = 0;
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_a = '0, m_b = '0;
  logic [31:0] m_pending = '0, m_result = '0, m_prev = '0;

  always @(posedge clk) begin
    if (rst) begin
      phase    = 0;
      m_result = '0;
      m_prev   = '0;
    end else if (phase == 0) begin
      if (start && !flush) begin
        phase     = 1;
        m_op      = op;
        m_a       = rs1;
        m_b       = rs2;
        m_pending = ref_calc(op, rs1, rs2);
      end
    end else if (flush) begin
      if (phase == 33) m_result = m_prev;
      phase = 0;
    end else if (phase == 33) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == 33) begin
        m_prev   = m_result;
        m_result = m_pending;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   busy,      phase != 0);
      check("done",   done,      (phase == 33) && !flush);
      check("stall",  stall_req, ((phase == 0) && start && !flush) || (phase >= 1 && phase <= 32));
      check("result", result,    m_result);
      if (phase >= 1 && phase <= 32) begin
        check("alu_signal run", alu_signal, m_op[1] ? 32'd1 : 32'd0);
        if (m_op[1]) check("alu_b divisor", alu_op_b, m_b);
        else         check("alu_b addend", (alu_op_b == 0) || (alu_op_b == m_a), 1);
      end else begin
        check("alu_a idle",      alu_op_a,   0);
        check("alu_b idle",      alu_op_b,   0);
        check("alu_signal idle", alu_signal, 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    // Scramble operand inputs so a late re-latch would corrupt the result
    start = 1'b0; op = ~o; rs1 = 32'hDEAD_BEEF; rs2 = 32'h0BAD_F00D;
  endtask

  // Waits for done; optionally pulses start with other operands at cycle poke_at
  task automatic wait_done(input string name, input logic [31:0] lit, input int poke_at);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == poke_at) begin
        start = 1'b1; op = 2'b10; rs1 = 32'd9; rs2 = 32'd2;
      end
      if (n == poke_at + 1) start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    check({name, " done seen"}, seen, 1);
    check({name, " latency"},   n,    33);
    check({name, " result"},    result,   lit);
    check({name, " model"},     m_result, lit);
  endtask

  // Aborts the running operation at cnt = 10 with flush (kind 0) or rst (kind 1)
  task automatic abort_op(input string name, input bit kind, input logic [31:0] lit);
    int n;
    int done_cnt;
    n = 0;
    while (n < 11) begin
      @(negedge clk);
      n++;
    end
    if (kind) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    check({name, " busy"},   busy,      0);
    check({name, " done"},   done,      0);
    check({name, " stall"},  stall_req, 0);
    check({name, " alu_a"},  alu_op_a,  0);
    check({name, " result"}, result,    lit);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check({name, " no done"}, done_cnt, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset busy",   busy,      0);
    check("reset done",   done,      0);
    check("reset stall",  stall_req, 0);
    check("reset result", result,    0);

    launch(2'b00, 32'd7, 32'd6);                wait_done("mul 7x6",       32'd42,        -1);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("mulhu max",     32'hFFFF_FFFE, -1);
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("mul max",       32'h0000_0001, -1);
    launch(2'b10, 32'd100, 32'd7);              wait_done("divu 100/7",    32'd14,        -1);
    launch(2'b11, 32'd100, 32'd7);              wait_done("remu 100/7",    32'd2,         -1);
    launch(2'b10, 32'h8000_0000, 32'd1);        wait_done("divu msb/1",    32'h8000_0000, -1);
    launch(2'b10, 32'd123, 32'd0);              wait_done("divu by zero",  32'hFFFF_FFFF, -1);
    launch(2'b11, 32'd123, 32'd0);              wait_done("remu by zero",  32'd123,       -1);
    // start pulsed during the cnt = 5 cycle is ignored
    launch(2'b00, 32'd3, 32'd5);                wait_done("mul start ignored", 32'd15,    6);
    launch(2'b01, 32'h1234_5678, 32'h10);       abort_op("flush cnt10", 1'b0, 32'd15);
    launch(2'b10, 32'd1000, 32'd3);             abort_op("rst cnt10",   1'b1, 32'd0);
    launch(2'b11, 32'd1000, 32'd7);             wait_done("remu after rst", 32'd6,        -1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
